branch_cond_reg: RTL and testbench

BRANCH_COND_REG -- requirements
Module: branch_cond_reg

---
 rtl/branch_cond_pkg.sv | 34 +++
 rtl/branch_cond_reg_cond_eval.sv | 46 ++++
 rtl/branch_cond_reg.sv | 132 +++++++++++++
 tb/tb_branch_cond_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_pkg.sv
// ---------------------------------------------------------------------------
// branch_cond_pkg
// Shared definitions for the branch condition register.
//   cond_code_e : the eight 3-bit branch condition codes carried in ir
//   state_e     : result-holding FSM states (IDLE = nothing held,
//                 HELD = con_out carries an unconsumed decision)
//   DEFAULT_COND_LSB / DEFAULT_STAT_W : default parameter values used by
//                 branch_cond_reg
// No ports (package).
// ---------------------------------------------------------------------------
package branch_cond_pkg;

    localparam int DEFAULT_COND_LSB = 19;
    localparam int DEFAULT_STAT_W   = 16;

    // Branch condition codes, evaluated against the two's complement bus.
    typedef enum logic [2:0] {
        COND_EQZ    = 3'b000,
        COND_NEZ    = 3'b001,
        COND_MSB0   = 3'b010,
        COND_MSB1   = 3'b011,
        COND_GTZ    = 3'b100,
        COND_LEZ    = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } cond_code_e;

    // Result register state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

endpackage

// File: rtl/branch_cond_reg_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational branch condition evaluator. Takes the 3-bit condition
// field extracted from the instruction register and the operand on the bus
// and produces the raw branch decision. Holds no state.
// Ports:
//   cond   [2:0]        in  : condition code field (see cond_code_e)
//   bus    [DATA_W-1:0] in  : operand under test, two's complement
//   result              out : 1 when the condition is satisfied
// ---------------------------------------------------------------------------
module cond_eval
    import branch_cond_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        cond,
    input  logic [DATA_W-1:0] bus,
    output logic              result
);

    cond_code_e code;
    logic       is_zero;
    logic       is_neg;

    assign code    = cond_code_e'(cond);
    assign is_zero = (bus == '0);
    assign is_neg  = bus[DATA_W-1];

    // Signed "greater than zero" is simply "not negative and not zero", so
    // no comparator is needed; "less or equal zero" is its complement.
    always_comb begin
        result = 1'b0;
        unique case (code)
            COND_EQZ:    result = is_zero;
            COND_NEZ:    result = !is_zero;
            COND_MSB0:   result = !is_neg;
            COND_MSB1:   result = is_neg;
            COND_GTZ:    result = !is_neg && !is_zero;
            COND_LEZ:    result = is_neg || is_zero;
            COND_ALWAYS: result = 1'b1;
            COND_NEVER:  result = 1'b0;
            default:     result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_reg.sv
// ---------------------------------------------------------------------------
// branch_cond_reg
// Registers a branch decision for the PC logic. On an evaluate strobe the
// condition field of ir is evaluated against bus and the result is held in
// con_out until the PC logic acknowledges it, a clear arrives, or a newer
// evaluation overwrites it. Priority each cycle: con_clr, con_in, pc_ack.
//
// Configuration macro: BRANCH_STATS_EN
//   When defined, adds saturating taken / not-taken statistics counters that
//   are cleared only by reset_n. When undefined the counter ports and logic
//   are absent and all other behaviour is unchanged.
//
// Ports:
//   clk                     in  : clock, rising edge active
//   reset_n                 in  : synchronous active-low reset
//   ir        [31:0]        in  : instruction register (condition field at
//                                 ir[COND_LSB+2:COND_LSB])
//   bus       [DATA_W-1:0]  in  : operand under test, two's complement
//   con_in                  in  : evaluate strobe
//   con_clr                 in  : clear held result
//   pc_ack                  in  : PC logic has consumed the result
//   con_out                 out : registered branch decision
//   taken_cnt [STAT_W-1:0]  out : taken evaluations (BRANCH_STATS_EN only)
//   not_taken_cnt [STAT_W-1:0] out : not-taken evaluations (BRANCH_STATS_EN)
//   con_valid               out : con_out holds an unconsumed result
// ---------------------------------------------------------------------------
module branch_cond_reg
    import branch_cond_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int COND_LSB = DEFAULT_COND_LSB,
    parameter int STAT_W   = DEFAULT_STAT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] bus,
    input  logic              con_in,
    input  logic              con_clr,
    input  logic              pc_ack,
    output logic              con_out,
`ifdef BRANCH_STATS_EN
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] not_taken_cnt,
`endif
    output logic              con_valid
);

    state_e state;
    logic   eval_result;
    logic   accept_eval;
    logic   unused_ir_bits;

    // Only the condition field of ir matters here; the remaining bits are
    // folded into a deliberately unused signal.
    assign unused_ir_bits = ^ir;

    cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .cond   (ir[COND_LSB+2:COND_LSB]),
        .bus    (bus),
        .result (eval_result)
    );

    // An evaluation is accepted only when it is not overridden by reset or
    // by a clear in the same cycle.
    assign accept_eval = reset_n && !con_clr && con_in;

    // Result FSM. con_out and con_valid are registered alongside the state so
    // they never follow bus combinationally. pc_ack only releases a held
    // result when no new evaluation arrives in the same cycle; otherwise the
    // new evaluation wins and the state stays HELD.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            con_out   <= 1'b0;
            con_valid <= 1'b0;
        end else if (con_clr) begin
            state     <= ST_IDLE;
            con_out   <= 1'b0;
            con_valid <= 1'b0;
        end else if (con_in) begin
            state     <= ST_HELD;
            con_out   <= eval_result;
            con_valid <= 1'b1;
        end else begin
            case (state)
                ST_HELD: begin
                    if (pc_ack) begin
                        state     <= ST_IDLE;
                        con_out   <= 1'b0;
                        con_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    con_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Statistics counters. Each accepted evaluation bumps exactly one of
    // them; both stick at all-ones and are cleared by reset only, so a
    // con_clr never disturbs the history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (accept_eval) begin
            if (eval_result) begin
                if (taken_cnt != '1) begin
                    taken_cnt <= taken_cnt + 1'b1;
                end
            end else begin
                if (not_taken_cnt != '1) begin
                    not_taken_cnt <= not_taken_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_accept_eval;
    localparam int UNUSED_STAT_W = STAT_W;

    // Without statistics the accept qualifier has no consumer.
    assign unused_accept_eval = accept_eval;
`endif

endmodule

// File: tb/tb_branch_cond_reg.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_reg
// Self-checking bench for branch_cond_reg: directed scenarios followed by a
// randomized run, each cycle compared against a behavioural model of the
// register. Counter checks are active when BRANCH_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_cond_reg;

    localparam int DATA_W   = 32;
    localparam int COND_LSB = 19;
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic              clk;
    logic              reset_n;
    logic [31:0]       ir;
    logic [DATA_W-1:0] bus;
    logic              con_in;
    logic              con_clr;
    logic              pc_ack;
    logic              con_out;
    logic              con_valid;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_cnt;
    logic [STAT_W-1:0] not_taken_cnt;
`endif

    int compare_count;
    int fail_count;

    bit exp_out;
    bit exp_valid;
    int exp_taken;
    int exp_not_taken;

    branch_cond_reg #(
        .DATA_W   (DATA_W),
        .COND_LSB (COND_LSB),
        .STAT_W   (STAT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ir            (ir),
        .bus           (bus),
        .con_in        (con_in),
        .con_clr       (con_clr),
        .pc_ack        (pc_ack),
        .con_out       (con_out),
`ifdef BRANCH_STATS_EN
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt),
`endif
        .con_valid     (con_valid)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decision: treat bus as a signed integer and apply the
    // condition table directly.
    function automatic bit refDecision(input int code, input logic [31:0] b);
        int signed v;
        v = signed'(b);
        case (code)
            0:       return v == 0;
            1:       return v != 0;
            2:       return v >= 0;
            3:       return v < 0;
            4:       return v > 0;
            5:       return v <= 0;
            6:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Build an ir with random filler and the given condition code in place.
    function automatic logic [31:0] makeIr(input int code);
        logic [31:0] r;
        r = $urandom;
        r[COND_LSB +: 3] = code[2:0];
        return r;
    endfunction

    // Model update for one clock edge, given the inputs present at that edge.
    task automatic modelStep(input bit rst_n, input int code, input logic [31:0] b,
                             input bit c_in, input bit c_clr, input bit ack);
        bit r;
        if (!rst_n) begin
            exp_out = 0; exp_valid = 0; exp_taken = 0; exp_not_taken = 0;
        end else if (c_clr) begin
            exp_out = 0; exp_valid = 0;
        end else if (c_in) begin
            r = refDecision(code, b);
            exp_out = r; exp_valid = 1;
            if (r) exp_taken = (exp_taken < STAT_MAX) ? exp_taken + 1 : STAT_MAX;
            else   exp_not_taken = (exp_not_taken < STAT_MAX) ? exp_not_taken + 1 : STAT_MAX;
        end else if (ack && exp_valid) begin
            exp_out = 0; exp_valid = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        compare_count++;
        assert (con_out === exp_out) else begin
            fail_count++;
            $error("[TB] FAIL %s con_out observed %0b expected %0b", tag, con_out, exp_out);
        end
        compare_count++;
        assert (con_valid === exp_valid) else begin
            fail_count++;
            $error("[TB] FAIL %s con_valid observed %0b expected %0b", tag, con_valid, exp_valid);
        end
`ifdef BRANCH_STATS_EN
        compare_count++;
        assert (int'(taken_cnt) === exp_taken) else begin
            fail_count++;
            $error("[TB] FAIL %s taken_cnt observed %0d expected %0d", tag, taken_cnt, exp_taken);
        end
        compare_count++;
        assert (int'(not_taken_cnt) === exp_not_taken) else begin
            fail_count++;
            $error("[TB] FAIL %s not_taken_cnt observed %0d expected %0d", tag, not_taken_cnt, exp_not_taken);
        end
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the
    // rising edge and compare shortly after it.
    task automatic applyStimulus(input string tag, input bit rst_n, input int code,
                                 input logic [31:0] b, input bit c_in,
                                 input bit c_clr, input bit ack);
        @(negedge clk);
        reset_n = rst_n;
        ir      = makeIr(code);
        bus     = b;
        con_in  = c_in;
        con_clr = c_clr;
        pc_ack  = ack;
        @(posedge clk);
        modelStep(rst_n, code, b, c_in, c_clr, ack);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        compare_count = 0;
        fail_count    = 0;
        exp_out = 0; exp_valid = 0; exp_taken = 0; exp_not_taken = 0;
        reset_n = 1'b0; ir = '0; bus = '0;
        con_in = 1'b0; con_clr = 1'b0; pc_ack = 1'b0;

        $display("[TB] reset");
        applyStimulus("reset",        0, 0, 32'h0, 0, 0, 0);
        applyStimulus("idle",         1, 0, 32'h0, 0, 0, 0);
        applyStimulus("idle_ack",     1, 0, 32'h0, 0, 0, 1);

        $display("[TB] eq-zero evaluate then acknowledge");
        applyStimulus("eqz_strobe",   1, 0, 32'h0, 1, 0, 0);
        applyStimulus("eqz_hold",     1, 0, 32'h5, 0, 0, 0);
        applyStimulus("eqz_ack",      1, 0, 32'h0, 0, 0, 1);

        $display("[TB] signed boundaries for codes 100 and 101");
        applyStimulus("gtz_zero",     1, 4, 32'h0000_0000, 1, 0, 0);
        applyStimulus("gtz_minneg",   1, 4, 32'h8000_0000, 1, 0, 0);
        applyStimulus("gtz_one",      1, 4, 32'h0000_0001, 1, 0, 0);
        applyStimulus("gtz_maxpos",   1, 4, 32'h7FFF_FFFF, 1, 0, 0);
        applyStimulus("lez_zero",     1, 5, 32'h0000_0000, 1, 0, 0);
        applyStimulus("lez_minneg",   1, 5, 32'h8000_0000, 1, 0, 0);
        applyStimulus("lez_one",      1, 5, 32'h0000_0001, 1, 0, 0);
        applyStimulus("msb1_neg",     1, 3, 32'hFFFF_FFFF, 1, 0, 0);
        applyStimulus("msb0_neg",     1, 2, 32'hFFFF_FFFF, 1, 0, 0);
        applyStimulus("nez_zero",     1, 1, 32'h0000_0000, 1, 0, 0);

        $display("[TB] overwrite with simultaneous ack");
        applyStimulus("always_load",  1, 6, 32'h1234_5678, 1, 0, 0);
        applyStimulus("never_ackin",  1, 7, 32'h1234_5678, 1, 0, 1);

        $display("[TB] clear wins over strobe and ack");
        applyStimulus("always_again", 1, 6, 32'h0, 1, 0, 0);
        applyStimulus("clr_all",      1, 6, 32'h0, 1, 1, 1);
        applyStimulus("after_clr",    1, 6, 32'h0, 0, 0, 0);

        $display("[TB] reset overrides strobe");
        applyStimulus("pre_rst_load", 1, 6, 32'h0, 1, 0, 0);
        applyStimulus("rst_with_in",  0, 6, 32'h0, 1, 0, 0);
        applyStimulus("post_rst",     1, 6, 32'h0, 0, 0, 0);

        $display("[TB] saturation run of taken evaluations");
        for (int i = 0; i < 17; i++) begin
            applyStimulus("sat_taken", 1, 6, $urandom, 1, 0, 0);
        end
        applyStimulus("sat_clr",      1, 7, 32'h0, 0, 1, 0);
        applyStimulus("sat_rst",      0, 0, 32'h0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            bit r_rst;
            bit r_in;
            bit r_clr;
            bit r_ack;
            r_rst = ($urandom_range(0, 39) != 0);
            r_in  = ($urandom_range(0, 2) == 0);
            r_clr = ($urandom_range(0, 9) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            applyStimulus("random", r_rst, $urandom_range(0, 7),
                          ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                          r_in, r_clr, r_ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
